// File: rtl/instr_encoder.sv
// Program loader: packs opcode/register/field tuples into 16-bit words and writes
// them to consecutive instruction-memory addresses. Optional macro FIELD_CHECK_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter bit          HALT_STOP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [3:0]        in_fa,
  input  logic [3:0]        in_fb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] wr_count
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned WORD_W = 16;
  localparam logic [OP_W-1:0] OP_HALT    = 5'b11011;
  localparam logic [OP_W-1:0] OP_MAX_LEG = 5'b11011;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [2:0]      rd;
    logic [3:0]      fa;
    logic [3:0]      fb;
  } instr_word_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_FIN    = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic                halt_q, halt_d;

  logic                in_ready_d, mem_we_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0]   mem_addr_d, wr_count_d;
  logic [WORD_W-1:0]   mem_wdata_d;

  instr_word_t         word_c;
  logic                legal_c;

  // Opcode range check, plus optional register-field checks.
  always_comb begin
    word_c  = '{op: in_op, rd: in_rd, fa: in_fa, fb: in_fb};
    legal_c = (in_op <= OP_MAX_LEG);
`ifdef FIELD_CHECK_EN
    if ((in_op == 5'b10000) || ((in_op >= 5'b00011) && (in_op <= 5'b01001)))
      legal_c = legal_c && !in_fa[3] && !in_fb[3];
    if ((in_op >= 5'b01010) && (in_op <= 5'b01101))
      legal_c = legal_c && !in_fa[3];
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    halt_d      = halt_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wr_count_d  = wr_count;
    err_d       = err;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          err_d = 1'b0;
          if (count != '0) begin
            addr_d      = base_addr;
            remaining_d = count;
            wr_count_d  = '0;
            state_d     = S_ACCEPT;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ACCEPT: begin
        if (in_valid && in_ready) begin
          if (legal_c) begin
            mem_addr_d  = addr_q;
            mem_wdata_d = WORD_W'(word_c);
            halt_d      = (in_op == OP_HALT);
            state_d     = S_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        addr_d      = addr_q + ADDR_W'(1);
        remaining_d = remaining_q - ADDR_W'(1);
        wr_count_d  = wr_count + ADDR_W'(1);
        if ((remaining_q == ADDR_W'(1)) || (HALT_STOP && halt_q))
          state_d = S_FIN;
        else
          state_d = S_ACCEPT;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs are decoded from the state being entered.
    in_ready_d = (state_d == S_ACCEPT);
    mem_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE) && (state_d != S_ERR);
    done_d     = done_d || (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      halt_q      <= 1'b0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wr_count    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      halt_q      <= halt_d;
      in_ready    <= in_ready_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      wr_count    <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed sessions plus randomized sessions checked
// against a session-level model (address/word list, remaining count, halt/illegal end).
module tb_instr_encoder;

  localparam int unsigned ADDR_W    = 8;
  localparam bit          HALT_STOP = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] count = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_op = '0;
  logic [2:0]        in_rd = '0;
  logic [3:0]        in_fa = '0;
  logic [3:0]        in_fb = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] wr_count;

  int tests = 0;
  int fails = 0;

  // Session model state
  int m_addr;
  int m_left;
  int m_wr;

  instr_encoder #(.ADDR_W(ADDR_W), .HALT_STOP(HALT_STOP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_fa(in_fa), .in_fb(in_fb), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 0);
    check({tag, "_we"},    32'(mem_we), 0);
    check({tag, "_addr"},  32'(mem_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_wrcnt"}, 32'(wr_count), 0);
  endtask

  task automatic do_start(input int b, input int c);
    start = 1'b1;
    base_addr = ADDR_W'(b);
    count = ADDR_W'(c);
    tick();
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    count = ADDR_W'($urandom);
    check("start_err", 32'(err), 0);
    if (c != 0) begin
      m_addr = b % 256;
      m_left = c;
      m_wr = 0;
      check("start_ready", 32'(in_ready), 1);
      check("start_busy", 32'(busy), 1);
    end else begin
      check("zero_done", 32'(done), 1);
      check("zero_busy", 32'(busy), 0);
      tick();
      check("zero_done_end", 32'(done), 0);
    end
  endtask

  // One handshake plus its outcome; 'ended' is set when the session is over.
  task automatic xfer(input logic [4:0] op, input logic [2:0] rd, input logic [3:0] fa,
                      input logic [3:0] fb, input int gap, output bit ended);
    bit legal;
    int word;
    legal = (int'(op) < 28);
`ifdef FIELD_CHECK_EN
    if (op == 5'b10000 || (int'(op) >= 3 && int'(op) <= 9)) legal = legal && fa < 8 && fb < 8;
    if (int'(op) >= 10 && int'(op) <= 13) legal = legal && fa < 8;
`endif
    word = int'(op) * 2048 + int'(rd) * 256 + int'(fa) * 16 + int'(fb);
    ended = 1'b0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      check("wait_ready", 32'(in_ready), 1);
      start = ($urandom_range(0, 1) == 1);
      base_addr = ADDR_W'($urandom);
      count = ADDR_W'($urandom);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_fa = fa; in_fb = fb;
    check("hs_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_op = 5'($urandom); in_rd = 3'($urandom); in_fa = 4'($urandom); in_fb = 4'($urandom);
    if (!legal) begin
      check("ill_we", 32'(mem_we), 0);
      check("ill_err", 32'(err), 1);
      check("ill_busy", 32'(busy), 0);
      check("ill_ready", 32'(in_ready), 0);
      ended = 1'b1;
      return;
    end
    check("wr_we", 32'(mem_we), 1);
    check("wr_addr", 32'(mem_addr), 32'(m_addr));
    check("wr_data", 32'(mem_wdata), 32'(word));
    m_addr = (m_addr + 1) % 256;
    m_left--;
    m_wr++;
    tick();
    check("post_we", 32'(mem_we), 0);
    if (m_left == 0 || (HALT_STOP && op == 5'b11011)) begin
      check("fin_done", 32'(done), 1);
      check("fin_wrcnt", 32'(wr_count), 32'(m_wr));
      check("fin_busy", 32'(busy), 1);
      check("fin_ready", 32'(in_ready), 0);
      tick();
      check("idle_done", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_ready", 32'(in_ready), 0);
      ended = 1'b1;
    end else begin
      check("next_done", 32'(done), 0);
      check("next_wrcnt", 32'(wr_count), 32'(m_wr));
    end
  endtask

  initial begin
    bit ended;
    logic [4:0] op;
    int b, c;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single ADD at 0x10
    do_start(8'h10, 1);
    xfer(5'b10000, 3'd1, 4'd2, 4'd3, 0, ended);
    check("t1_ended", 32'(ended), 1);
    check("t1_hold", 32'(mem_wdata), 32'h8123);
    check("t1_wrcnt", 32'(wr_count), 1);

    // Address wrap 0xFF -> 0x00
    do_start(8'hFF, 2);
    xfer(5'b10001, 3'd2, 4'd0, 4'd5, 1, ended);
    xfer(5'b00001, 3'd0, 4'd0, 4'd0, 0, ended);
    check("t2_ended", 32'(ended), 1);
    check("t2_addr", 32'(mem_addr), 32'h00);
    check("t2_data", 32'(mem_wdata), 32'h0800);

    // HALT ends the session early
    do_start(8'h20, 5);
    xfer(5'b10010, 3'd1, 4'd2, 4'd3, 0, ended);
    check("t3_not_ended", 32'(ended), 0);
    xfer(5'b11011, 3'd0, 4'd0, 4'd0, 0, ended);
    check("t3_ended", 32'(ended), 1);
    check("t3_data", 32'(mem_wdata), 32'hD800);
    check("t3_wrcnt", 32'(wr_count), 2);
    tick();
    check("t3_ready_low", 32'(in_ready), 0);

    // Illegal opcode, then restart from ERR
    do_start(8'h30, 3);
    xfer(5'b11100, 3'd0, 4'd0, 4'd0, 0, ended);
    tick();
    check("t4_err_sticky", 32'(err), 1);
    check("t4_no_we", 32'(mem_we), 0);
    check("t4_busy", 32'(busy), 0);
    do_start(8'h31, 1);
    xfer(5'b00010, 3'd4, 4'd1, 4'd1, 0, ended);
    check("t4_recover", 32'(ended), 1);

    // Zero-count session
    do_start(8'h50, 0);

    // Reset during WRITE
    do_start(8'h40, 3);
    in_valid = 1'b1;
    in_op = 5'b00010; in_rd = 3'd3; in_fa = 4'd4; in_fb = 4'd5;
    tick();
    in_valid = 1'b0;
    check("t5_in_write", 32'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_abort");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t5_idle", 32'(busy), 0);
    do_start(8'h60, 1);
    xfer(5'b00101, 3'd2, 4'd3, 4'd4, 0, ended);
    check("t5_clean", 32'(ended), 1);

    // ADD with fa[3] set: rejected only when field checks are built in
    do_start(8'h70, 1);
    xfer(5'b10000, 3'd0, 4'h9, 4'd3, 0, ended);
`ifndef FIELD_CHECK_EN
    check("t6_data", 32'(mem_wdata), 32'h8093);
    check("t6_err", 32'(err), 0);
`else
    check("t6_err", 32'(err), 1);
`endif

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      b = (s % 5 == 0) ? $urandom_range(250, 255) : $urandom_range(0, 255);
      c = (s % 9 == 4) ? 0 : $urandom_range(1, 7);
      do_start(b, c);
      if (c == 0) continue;
      for (int i = 0; i < c; i++) begin
        op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 26));
        xfer(op, 3'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 2), ended);
        if (ended) break;
      end
      check("rnd_session_end", 32'(ended), 1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
